// File: rtl/npu_mem_pkg.sv
// ---------------------------------------------------------------------------
// npu_mem_pkg
// Shared types and constants for the NPU matrix-memory port arbiter:
// bank count, word-address width, word/bank types, the requester enum used
// for round-robin bookkeeping, and a bank one-hot decode helper.
// ---------------------------------------------------------------------------
package npu_mem_pkg;

    localparam int BANKS   = 4;
    localparam int WORD_AW = 13;

    typedef logic [15:0] word_t;
    typedef logic [1:0]  bank_t;

    // Which requester was served last; used to break ties on contention.
    typedef enum logic {
        SRC_READ  = 1'b0,
        SRC_WRITE = 1'b1
    } src_e;

    function automatic logic [BANKS-1:0] bank_onehot(input bank_t bank);
        logic [BANKS-1:0] oh;
        oh       = '0;
        oh[bank] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/npu_rd_lat_pipe.sv
// ---------------------------------------------------------------------------
// npu_rd_lat_pipe
// Fixed-latency tracker for issued reads: a DEPTH-stage shift register of
// (valid, bank) pairs. The last stage tells the arbiter which bank's data is
// arriving this cycle.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   vld_i      a read is issued this cycle
//   bank_i     bank of the issued read
//   vld_o      read data from bank_o is valid this cycle
//   bank_o     bank whose read data is arriving
//   any_vld_o  at least one read is in flight
// ---------------------------------------------------------------------------
module npu_rd_lat_pipe
    import npu_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  vld_i,
    input  bank_t bank_i,
    output logic  vld_o,
    output bank_t bank_o,
    output logic  any_vld_o
);

    logic [DEPTH-1:0] vld_q;
    bank_t            bank_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // NOTE: the bank payload is not reset; it is only looked at when the
    // matching valid bit is set, and valid is cleared by reset.
    always_ff @(posedge clk) begin
        bank_q[0] <= bank_i;
        for (int i = 1; i < DEPTH; i++) begin
            bank_q[i] <= bank_q[i-1];
        end
    end

    assign vld_o     = vld_q[DEPTH-1];
    assign bank_o    = bank_q[DEPTH-1];
    assign any_vld_o = |vld_q;

endmodule

// File: rtl/npu_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// npu_mem_port_arbiter
// Single-port scheduler in front of the 4-bank x 8192-word x 16-bit NPU
// matrix memory. Packs a host byte-write stream into 16-bit word commits and
// shares the one address/data path with the compute engine's word reads.
// At most one memory operation is issued per cycle; on contention the
// requester not served last wins. Reads return exactly READ_LAT cycles after
// issue. There is no write-to-read forwarding.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   wr_valid/wr_ready    host byte handshake (wr_ready low while a commit
//                        is outstanding)
//   wr_addr, wr_byte     host byte address and data
//   wr_err               sticky: odd byte arrived without matching even byte
//   rd_req, rd_addr      compute read request, address held until rd_gnt
//   rd_gnt               read issued this cycle
//   rd_valid, rd_data    read data return, READ_LAT cycles after rd_gnt
//   mem_we               one-hot bank write enable
//   mem_addr             word address to all banks (holds when idle)
//   mem_wdata            write word
//   mem_q                per-bank read data, index = bank
//   busy                 commit pending or reads in flight
//   stall_wr, stall_rd   saturating wait-cycle counters, present only when
//                        NPU_ARB_STATS_EN is defined
//
// Parameters: READ_LAT (1..3), ADDR_W (byte address width, bank = top 2 bits)
// ---------------------------------------------------------------------------
module npu_mem_port_arbiter
    import npu_mem_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_byte,
    output logic               wr_err,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_gnt,
    output logic               rd_valid,
    output word_t              rd_data,
    output logic [BANKS-1:0]   mem_we,
    output logic [WORD_AW-1:0] mem_addr,
    output word_t              mem_wdata,
    input  word_t              mem_q [BANKS],
`ifdef NPU_ARB_STATS_EN
    output logic [15:0]        stall_wr,
    output logic [15:0]        stall_rd,
`endif
    output logic               busy
);

    // Word-granular address: bank in the top 2 bits, word index at the bottom.
    localparam int WA_W = ADDR_W - 1;
    typedef logic [WA_W-1:0] waddr_t;

    logic               lo_valid_q,    lo_valid_d;
    logic [7:0]         lo_byte_q,     lo_byte_d;
    waddr_t             lo_word_q,     lo_word_d;
    logic               commit_pend_q, commit_pend_d;
    waddr_t             commit_addr_q, commit_addr_d;
    word_t              commit_data_q, commit_data_d;
    logic               wr_err_q,      wr_err_d;
    src_e               rr_last_q,     rr_last_d;
    logic [WORD_AW-1:0] mem_addr_q,    mem_addr_d;

    logic   issue_wr, issue_rd, wr_fire;
    waddr_t wr_waddr;
    logic   pipe_vld, pipe_any;
    bank_t  pipe_bank;

    // Only the word address of a read matters; the byte lane bit is dropped.
    logic unused_rd_lsb;
    assign unused_rd_lsb = rd_addr[0];

    assign wr_ready = !commit_pend_q;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_waddr = wr_addr[ADDR_W-1:1];

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        if (commit_pend_q && rd_req) begin
            // Contention: serve whoever did not get the last operation.
            if (rr_last_q == SRC_READ) issue_wr = 1'b1;
            else                       issue_rd = 1'b1;
        end else if (commit_pend_q) begin
            issue_wr = 1'b1;
        end else if (rd_req) begin
            issue_rd = 1'b1;
        end
    end

    always_comb begin
        mem_addr = mem_addr_q;
        if (issue_wr)      mem_addr = commit_addr_q[WORD_AW-1:0];
        else if (issue_rd) mem_addr = rd_addr[WORD_AW:1];
    end

    assign mem_we    = issue_wr ? bank_onehot(commit_addr_q[WA_W-1 -: 2]) : '0;
    assign mem_wdata = issue_wr ? commit_data_q : '0;
    assign rd_gnt    = issue_rd;
    assign wr_err    = wr_err_q;

    always_comb begin
        lo_valid_d    = lo_valid_q;
        lo_byte_d     = lo_byte_q;
        lo_word_d     = lo_word_q;
        commit_pend_d = commit_pend_q;
        commit_addr_d = commit_addr_q;
        commit_data_d = commit_data_q;
        wr_err_d      = wr_err_q;
        rr_last_d     = rr_last_q;
        mem_addr_d    = mem_addr;

        if (issue_wr) commit_pend_d = 1'b0;

        // A byte is only accepted with no commit outstanding, so acceptance
        // never coincides with a write issue.
        if (wr_fire) begin
            if (!wr_addr[0]) begin
                lo_valid_d = 1'b1;
                lo_byte_d  = wr_byte;
                lo_word_d  = wr_waddr;
            end else begin
                commit_pend_d = 1'b1;
                commit_addr_d = wr_waddr;
                lo_valid_d    = 1'b0;
                if (lo_valid_q && (lo_word_q == wr_waddr)) begin
                    commit_data_d = {wr_byte, lo_byte_q};
                end else begin
                    commit_data_d = {wr_byte, 8'h00};
                    wr_err_d      = 1'b1;
                end
            end
        end

        if (issue_wr)      rr_last_d = SRC_WRITE;
        else if (issue_rd) rr_last_d = SRC_READ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_valid_q    <= 1'b0;
            lo_byte_q     <= '0;
            lo_word_q     <= '0;
            commit_pend_q <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
            wr_err_q      <= 1'b0;
            rr_last_q     <= SRC_READ;
            mem_addr_q    <= '0;
        end else begin
            lo_valid_q    <= lo_valid_d;
            lo_byte_q     <= lo_byte_d;
            lo_word_q     <= lo_word_d;
            commit_pend_q <= commit_pend_d;
            commit_addr_q <= commit_addr_d;
            commit_data_q <= commit_data_d;
            wr_err_q      <= wr_err_d;
            rr_last_q     <= rr_last_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    npu_rd_lat_pipe #(
        .DEPTH(READ_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .vld_i    (issue_rd),
        .bank_i   (rd_addr[ADDR_W-1 -: 2]),
        .vld_o    (pipe_vld),
        .bank_o   (pipe_bank),
        .any_vld_o(pipe_any)
    );

    assign rd_valid = pipe_vld;
    assign rd_data  = pipe_vld ? mem_q[pipe_bank] : '0;
    assign busy     = commit_pend_q || pipe_any;

`ifdef NPU_ARB_STATS_EN
    logic [15:0] stall_wr_q, stall_rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_wr_q <= '0;
            stall_rd_q <= '0;
        end else begin
            if (commit_pend_q && !issue_wr && (stall_wr_q != 16'hFFFF))
                stall_wr_q <= stall_wr_q + 16'd1;
            if (rd_req && !issue_rd && (stall_rd_q != 16'hFFFF))
                stall_rd_q <= stall_rd_q + 16'd1;
        end
    end

    assign stall_wr = stall_wr_q;
    assign stall_rd = stall_rd_q;
`endif

endmodule

// File: tb/tb_npu_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_npu_mem_port_arbiter
// Two arbiter instances share clock and reset: dut (READ_LAT=1) and dut3
// (READ_LAT=3). Memory read data is a per-bank pattern tagged with the
// current cycle, so returned data identifies both its bank and its timing.
// Expected writes and read returns are queued by the stimulus and popped by
// negedge monitors; timing-sensitive handshake values are checked directly.
// ---------------------------------------------------------------------------
module tb_npu_mem_port_arbiter;
    import npu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        wr_valid, wr_ready, wr_err, rd_req, rd_gnt, rd_valid, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_byte;
    word_t       rd_data, mem_wdata;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;

    logic        wr3_valid, wr3_ready, wr3_err, rd3_req, rd3_gnt, rd3_valid, busy3;
    logic [15:0] wr3_addr, rd3_addr;
    logic [7:0]  wr3_byte;
    word_t       rd3_data, mem3_wdata;
    logic [3:0]  mem3_we;
    logic [12:0] mem3_addr;

`ifdef NPU_ARB_STATS_EN
    logic [15:0] stall_wr, stall_rd, stall3_wr, stall3_rd;
`endif

    word_t       mem_q [4];
    word_t       fixed_q [4];
    logic        use_fixed = 1'b0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [3:0]  we;
        logic [12:0] addr;
        word_t       data;
    } wr_exp_t;

    wr_exp_t exp_wr[$];
    wr_exp_t exp_wr3[$];
    word_t   exp_rd[$];
    word_t   exp_rd3[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t pat(input int b, input int unsigned c);
        return {b[1:0], 2'b10, c[11:0]};
    endfunction

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            mem_q[b] = use_fixed ? fixed_q[b] : pat(b, cyc);
        end
    end

    npu_mem_port_arbiter #(.READ_LAT(1), .ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_byte  (wr_byte),
        .wr_err   (wr_err),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_q    (mem_q),
`ifdef NPU_ARB_STATS_EN
        .stall_wr (stall_wr),
        .stall_rd (stall_rd),
`endif
        .busy     (busy)
    );

    npu_mem_port_arbiter #(.READ_LAT(3), .ADDR_W(16)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr3_valid),
        .wr_ready (wr3_ready),
        .wr_addr  (wr3_addr),
        .wr_byte  (wr3_byte),
        .wr_err   (wr3_err),
        .rd_req   (rd3_req),
        .rd_addr  (rd3_addr),
        .rd_gnt   (rd3_gnt),
        .rd_valid (rd3_valid),
        .rd_data  (rd3_data),
        .mem_we   (mem3_we),
        .mem_addr (mem3_addr),
        .mem_wdata(mem3_wdata),
        .mem_q    (mem_q),
`ifdef NPU_ARB_STATS_EN
        .stall_wr (stall3_wr),
        .stall_rd (stall3_rd),
`endif
        .busy     (busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: sample away from the active edge.
    always @(negedge clk) begin
        wr_exp_t e;
        word_t   d;
        if (rst) begin
            if (mem_we != 4'b0000) begin
                check("wr1_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr1_we", 32'(mem_we), 32'(e.we));
                    check("wr1_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr1_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (rd_valid) begin
                check("rd1_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    d = exp_rd.pop_front();
                    check("rd1_data", 32'(rd_data), 32'(d));
                end
            end
            if (mem3_we != 4'b0000) begin
                check("wr3_expected", 32'(exp_wr3.size() != 0), 32'd1);
                if (exp_wr3.size() != 0) begin
                    e = exp_wr3.pop_front();
                    check("wr3_we", 32'(mem3_we), 32'(e.we));
                    check("wr3_addr", 32'(mem3_addr), 32'(e.addr));
                    check("wr3_data", 32'(mem3_wdata), 32'(e.data));
                end
            end
            if (rd3_valid) begin
                check("rd3_expected", 32'(exp_rd3.size() != 0), 32'd1);
                if (exp_rd3.size() != 0) begin
                    d = exp_rd3.pop_front();
                    check("rd3_data", 32'(rd3_data), 32'(d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required $finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b_addr [6];
        logic [7:0]  b_dat  [6];
        logic [15:0] r3_addr [4];
        int          bi;
        int          phase;

        wr_valid = 0; wr_addr = '0; wr_byte = '0; rd_req = 0; rd_addr = '0;
        wr3_valid = 0; wr3_addr = '0; wr3_byte = '0; rd3_req = 0; rd3_addr = '0;
        fixed_q[0] = 16'h1111; fixed_q[1] = 16'h2222;
        fixed_q[2] = 16'h5A5A; fixed_q[3] = 16'h4444;

        // ---------------- reset state ----------------
        rst = 0;
        repeat (3) step();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        rst = 1;
        step();
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_wr3_ready", 32'(wr3_ready), 32'd1);

        // ---------------- T1: byte pair packing ----------------
        exp_wr.push_back('{we: 4'b0010, addr: 13'd0, data: 16'h1234});
        wr_valid = 1; wr_addr = 16'h4000; wr_byte = 8'h34; #1;
        check("t1_ready_even", 32'(wr_ready), 32'd1);
        step();
        wr_addr = 16'h4001; wr_byte = 8'h12; #1;
        check("t1_ready_odd", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 0; #1;
        check("t1_ready_low", 32'(wr_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_we", 32'(mem_we), 32'h2);
        step();
        check("t1_ready_back", 32'(wr_ready), 32'd1);
        check("t1_no_err", 32'(wr_err), 32'd0);

        // ---------------- T2: unmatched odd byte ----------------
        exp_wr.push_back('{we: 4'b1000, addr: 13'd1, data: 16'hAB00});
        wr_valid = 1; wr_addr = 16'hC003; wr_byte = 8'hAB; #1;
        step();
        wr_valid = 0; #1;
        check("t2_err_set", 32'(wr_err), 32'd1);
        step();
        check("t2_addr_hold", 32'(mem_addr), 32'd1);
        step();
        check("t2_err_sticky", 32'(wr_err), 32'd1);

        // ---------------- T3: single read, READ_LAT=1 ----------------
        use_fixed = 1;
        rd_req = 1; rd_addr = 16'h8004; #1;
        check("t3_gnt", 32'(rd_gnt), 32'd1);
        check("t3_addr", 32'(mem_addr), 32'd2);
        check("t3_we", 32'(mem_we), 32'd0);
        exp_rd.push_back(16'h5A5A);
        step();
        rd_req = 0; #1;
        check("t3_gnt_drop", 32'(rd_gnt), 32'd0);
        check("t3_valid", 32'(rd_valid), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        step();
        check("t3_valid_pulse", 32'(rd_valid), 32'd0);
        check("t3_addr_hold", 32'(mem_addr), 32'd2);
        use_fixed = 0;

        // ---------------- T4: continuous reads + byte stream ----------------
        b_addr[0] = 16'h0020; b_dat[0] = 8'hA1;
        b_addr[1] = 16'h0021; b_dat[1] = 8'hB2;
        b_addr[2] = 16'h0022; b_dat[2] = 8'hC3;
        b_addr[3] = 16'h0023; b_dat[3] = 8'hD4;
        b_addr[4] = 16'h0024; b_dat[4] = 8'hE5;
        b_addr[5] = 16'h0025; b_dat[5] = 8'hF6;
        exp_wr.push_back('{we: 4'b0001, addr: 13'h10, data: 16'hB2A1});
        exp_wr.push_back('{we: 4'b0001, addr: 13'h11, data: 16'hD4C3});
        exp_wr.push_back('{we: 4'b0001, addr: 13'h12, data: 16'hF6E5});
        bi = 0;
        rd_req = 1; rd_addr = 16'h4002;
        for (int i = 0; i < 9; i++) begin
            phase = i % 3;
            if (bi < 6) begin
                wr_valid = 1; wr_addr = b_addr[bi]; wr_byte = b_dat[bi];
            end else begin
                wr_valid = 0;
            end
            #1;
            check("t4_gnt", 32'(rd_gnt), 32'(phase != 2));
            check("t4_ready", 32'(wr_ready), 32'(phase != 2));
            if (phase != 2) exp_rd.push_back(pat(1, cyc + 1));
            if (wr_valid && wr_ready) bi++;
            step();
        end
        rd_req = 0; wr_valid = 0; #1;
`ifdef NPU_ARB_STATS_EN
        check("t4_stall_rd", 32'(stall_rd), 32'd3);
        check("t4_stall_wr", 32'(stall_wr), 32'd0);
`endif

        // ---------------- T5: tie-break after a write, no forwarding ----------------
        exp_wr.push_back('{we: 4'b0001, addr: 13'h20, data: 16'h6677});
        wr_valid = 1; wr_addr = 16'h0040; wr_byte = 8'h77; #1;
        step();
        wr_addr = 16'h0041; wr_byte = 8'h66; #1;
        step();
        wr_valid = 0; rd_req = 1; rd_addr = 16'h0040; #1;
        check("t5_read_wins", 32'(rd_gnt), 32'd1);
        check("t5_read_no_we", 32'(mem_we), 32'd0);
        check("t5_read_addr", 32'(mem_addr), 32'h20);
        exp_rd.push_back(pat(0, cyc + 1));
        step();
        check("t5_write_next", 32'(mem_we), 32'h1);
        check("t5_read_waits", 32'(rd_gnt), 32'd0);
        step();
        check("t5_read_again", 32'(rd_gnt), 32'd1);
        exp_rd.push_back(pat(0, cyc + 1));
        step();
        rd_req = 0; #1;
`ifdef NPU_ARB_STATS_EN
        check("t5_stall_wr", 32'(stall_wr), 32'd1);
        check("t5_stall_rd", 32'(stall_rd), 32'd4);
`endif
        step();

        // ---------------- T6: READ_LAT=3 back-to-back reads ----------------
        r3_addr[0] = 16'h0000; r3_addr[1] = 16'h4000;
        r3_addr[2] = 16'h8000; r3_addr[3] = 16'hC000;
        for (int j = 0; j < 4; j++) begin
            rd3_req = 1; rd3_addr = r3_addr[j]; #1;
            check("t6_gnt", 32'(rd3_gnt), 32'd1);
            check("t6_valid_timing", 32'(rd3_valid), 32'(j == 3));
            exp_rd3.push_back(pat(j, cyc + 3));
            step();
        end
        rd3_req = 0;
        repeat (3) step();
        check("t6_valid_done", 32'(rd3_valid), 32'd0);
        check("t6_busy_done", 32'(busy3), 32'd0);

        // ---------------- T7: reset mid-operation ----------------
        wr3_valid = 1; wr3_addr = 16'h0002; wr3_byte = 8'h11;
        rd3_req = 1; rd3_addr = 16'h0000; #1;
        step();
        wr3_addr = 16'h0003; wr3_byte = 8'h22; rd3_addr = 16'h4000; #1;
        step();
        wr3_valid = 0; rd3_req = 0; #1;
        check("t7_busy_before", 32'(busy3), 32'd1);
        rst = 0; #1;
        check("t7_rst_we", 32'(mem3_we), 32'd0);
        check("t7_rst_addr", 32'(mem3_addr), 32'd0);
        check("t7_rst_valid", 32'(rd3_valid), 32'd0);
        check("t7_rst_busy", 32'(busy3), 32'd0);
        step();
        step();
        rst = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t7_no_valid", 32'(rd3_valid), 32'd0);
            check("t7_no_we", 32'(mem3_we), 32'd0);
            check("t7_ready", 32'(wr3_ready), 32'd1);
        end
        check("t7_busy_after", 32'(busy3), 32'd0);
        check("t7_err_cleared", 32'(wr_err), 32'd0);

        // ---------------- drain ----------------
        check("sb_wr_drained", 32'(exp_wr.size()), 32'd0);
        check("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
        check("sb_wr3_drained", 32'(exp_wr3.size()), 32'd0);
        check("sb_rd3_drained", 32'(exp_rd3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
